// File: rtl/rfm_issuer_bank.sv
// Per-bank ACT/RFM command issuer: accepts scheduler activations, tracks the
// rolling accumulated ACT count and spaces ACT/RFM pulses to the tracking unit.
module rfm_issuer_bank #(
    parameter int ADDR_SIZE = 18,
    parameter int RAA_W     = 6,
    parameter int RAA_IMT   = 16,
    parameter int ACT_GAP   = 5,
    parameter int RFM_GAP   = 8,
    parameter int GAP_W     = 4,
    parameter int RFM_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 act_valid,
    input  logic [ADDR_SIZE-1:0] act_req_addr,
    output logic                 act_ready,
    input  logic                 rfm_req,
    output logic                 act_cmd,
    output logic [ADDR_SIZE-1:0] act_addr,
    output logic                 rfm_cmd,
    output logic [RAA_W-1:0]     raa_cnt,
    output logic [RFM_CNT_W-1:0] rfm_total
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACT_WAIT = 2'd1;
    localparam logic [1:0] S_RFM_WAIT = 2'd2;

    localparam logic [RAA_W-1:0] IMT        = RAA_W'(RAA_IMT);
    localparam logic [GAP_W-1:0] ACT_RELOAD = GAP_W'(ACT_GAP - 1);
    localparam logic [GAP_W-1:0] RFM_RELOAD = GAP_W'(RFM_GAP - 1);

    logic [1:0]           r_state;
    logic [GAP_W-1:0]     r_gap;
    logic                 r_act_cmd;
    logic [ADDR_SIZE-1:0] r_act_addr;
    logic                 r_rfm_cmd;
    logic [RAA_W-1:0]     r_raa;
    logic [RFM_CNT_W-1:0] r_rfm_total;

    logic             w_idle;
    logic             w_at_imt;
    logic             w_issue_act;
    logic             w_issue_rfm;
    logic [RAA_W-1:0] w_raa_after_rfm;

    assign w_idle   = (r_state == S_IDLE);
    assign w_at_imt = (r_raa >= IMT);

    // Priority in IDLE: mandatory RFM, then ACT, then opportunistic RFM.
    assign w_issue_act = w_idle && !w_at_imt && act_valid;
    assign w_issue_rfm = w_idle && (w_at_imt ||
                         (!act_valid && rfm_req && (r_raa != '0)));

    // An opportunistic RFM below threshold saturates the count to zero.
    assign w_raa_after_rfm = w_at_imt ? (r_raa - IMT) : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_gap       <= '0;
            r_act_cmd   <= 1'b0;
            r_act_addr  <= '0;
            r_rfm_cmd   <= 1'b0;
            r_raa       <= '0;
            r_rfm_total <= '0;
        end else begin
            r_act_cmd  <= w_issue_act;
            r_rfm_cmd  <= w_issue_rfm;
            r_act_addr <= w_issue_act ? act_req_addr : '0;
            if (w_issue_act) begin
                r_raa   <= r_raa + RAA_W'(1);
                r_gap   <= ACT_RELOAD;
                r_state <= S_ACT_WAIT;
            end else if (w_issue_rfm) begin
                r_raa       <= w_raa_after_rfm;
                r_rfm_total <= r_rfm_total + RFM_CNT_W'(1);
                r_gap       <= RFM_RELOAD;
                r_state     <= S_RFM_WAIT;
            end else if (!w_idle) begin
                if (r_gap == GAP_W'(1)) begin
                    r_state <= S_IDLE;
                    r_gap   <= '0;
                end else begin
                    r_gap <= r_gap - GAP_W'(1);
                end
            end
        end
    end

    assign act_ready = w_idle && !w_at_imt;
    assign act_cmd   = r_act_cmd;
    assign act_addr  = r_act_addr;
    assign rfm_cmd   = r_rfm_cmd;
    assign raa_cnt   = r_raa;
    assign rfm_total = r_rfm_total;

endmodule

// File: tb/tb_rfm_issuer_bank.sv
// Directed and randomized checks of rfm_issuer_bank with RAA_IMT=4,
// ACT_GAP=5, RFM_GAP=8.
module tb_rfm_issuer_bank;

    localparam int ADDR_SIZE = 18;
    localparam int RAA_W     = 6;
    localparam int RAA_IMT   = 4;
    localparam int ACT_GAP   = 5;
    localparam int RFM_GAP   = 8;
    localparam int GAP_W     = 4;
    localparam int RFM_CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 act_valid;
    logic [ADDR_SIZE-1:0] act_req_addr;
    logic                 act_ready;
    logic                 rfm_req;
    logic                 act_cmd;
    logic [ADDR_SIZE-1:0] act_addr;
    logic                 rfm_cmd;
    logic [RAA_W-1:0]     raa_cnt;
    logic [RFM_CNT_W-1:0] rfm_total;

    int total = 0;
    int bad   = 0;

    rfm_issuer_bank #(
        .ADDR_SIZE(ADDR_SIZE), .RAA_W(RAA_W), .RAA_IMT(RAA_IMT),
        .ACT_GAP(ACT_GAP), .RFM_GAP(RFM_GAP), .GAP_W(GAP_W),
        .RFM_CNT_W(RFM_CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .act_valid(act_valid),
        .act_req_addr(act_req_addr), .act_ready(act_ready),
        .rfm_req(rfm_req), .act_cmd(act_cmd), .act_addr(act_addr),
        .rfm_cmd(rfm_cmd), .raa_cnt(raa_cnt), .rfm_total(rfm_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (act_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({tag, "_timeout"}, 32'(act_ready), 32'd1);
    endtask

    task automatic do_act(input logic [ADDR_SIZE-1:0] a, input string tag);
        wait_ready(tag);
        act_valid    = 1'b1;
        act_req_addr = a;
        tick();
        act_valid = 1'b0;
        check({tag, "_cmd"}, 32'(act_cmd), 32'd1);
        check({tag, "_addr"}, 32'(act_addr), 32'(a));
    endtask

    initial begin
        int any_pulse;
        int last_cyc, last_gap, cyc, exp_rfm, exp_raa;
        logic acc;
        logic [ADDR_SIZE-1:0] acc_addr;

        rstn = 1'b0; act_valid = 1'b0; act_req_addr = '0; rfm_req = 1'b0;
        tick(); tick();
        check("rst_act_cmd", 32'(act_cmd), 32'd0);
        check("rst_raa", 32'(raa_cnt), 32'd0);
        rstn = 1'b1;

        // Idle 10 cycles
        any_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (act_cmd || rfm_cmd || act_addr != '0) any_pulse++;
        end
        check("idle_no_pulse", 32'(any_pulse), 32'd0);
        check("idle_raa", 32'(raa_cnt), 32'd0);
        check("idle_total", 32'(rfm_total), 32'd0);
        check("idle_ready", 32'(act_ready), 32'd1);

        // Back-to-back ACTs up to threshold, then mandatory RFM
        act_valid = 1'b1;
        act_req_addr = 18'h10;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                for (int j = 0; j < 4; j++) begin
                    tick();
                    check("gap_act_quiet", 32'(act_cmd), 32'd0);
                end
                tick();
            end
            check("burst_act_cmd", 32'(act_cmd), 32'd1);
            check("burst_addr", 32'(act_addr), 32'(18'h10 + k));
            check("burst_raa", 32'(raa_cnt), 32'(k + 1));
            act_req_addr = ADDR_SIZE'(18'h11 + k);
            if (k == 3) check("ready_low_N15", 32'(act_ready), 32'd0);
        end
        for (int j = 16; j <= 26; j++) begin
            tick();
            check("ready_low_wait", 32'(act_ready), 32'd0);
            if (j == 16) check("addr_cleared", 32'(act_addr), 32'd0);
            if (j == 20) begin
                check("mand_rfm_cmd", 32'(rfm_cmd), 32'd1);
                check("mand_rfm_act_off", 32'(act_cmd), 32'd0);
                check("mand_rfm_raa", 32'(raa_cnt), 32'd0);
                check("mand_rfm_total", 32'(rfm_total), 32'd1);
            end
        end
        tick();
        check("ready_N27", 32'(act_ready), 32'd1);
        check("no_act_N27", 32'(act_cmd), 32'd0);
        tick();
        check("act_N28", 32'(act_cmd), 32'd1);
        check("act_N28_addr", 32'(act_addr), 32'h14);
        check("act_N28_raa", 32'(raa_cnt), 32'd1);
        act_valid = 1'b0;

        // Opportunistic RFM at raa=3
        do_act(18'h20, "opp_pre1");
        do_act(18'h21, "opp_pre2");
        check("opp_raa3", 32'(raa_cnt), 32'd3);
        wait_ready("opp");
        rfm_req = 1'b1;
        tick();
        rfm_req = 1'b0;
        check("opp_rfm_cmd", 32'(rfm_cmd), 32'd1);
        check("opp_raa", 32'(raa_cnt), 32'd0);
        check("opp_total", 32'(rfm_total), 32'd2);
        for (int j = 0; j < 7; j++) begin
            check("opp_ready_low", 32'(act_ready), 32'd0);
            tick();
        end
        check("opp_ready_back", 32'(act_ready), 32'd1);

        // rfm_req with raa=0 is ignored
        rfm_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("rfm_raa0_ignored", 32'(rfm_cmd), 32'd0);
        end
        rfm_req = 1'b0;
        check("rfm_raa0_total", 32'(rfm_total), 32'd2);

        // ACT beats simultaneous rfm_req
        do_act(18'h30, "sim_pre1");
        do_act(18'h31, "sim_pre2");
        wait_ready("sim");
        act_valid = 1'b1; rfm_req = 1'b1; act_req_addr = 18'h3ABCD;
        tick();
        act_valid = 1'b0; rfm_req = 1'b0;
        check("sim_act_cmd", 32'(act_cmd), 32'd1);
        check("sim_addr", 32'(act_addr), 32'h3ABCD);
        check("sim_rfm_off", 32'(rfm_cmd), 32'd0);
        check("sim_raa", 32'(raa_cnt), 32'd3);

        // Reset two cycles into ACT_WAIT
        tick(); tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("midrst_raa", 32'(raa_cnt), 32'd0);
        check("midrst_total", 32'(rfm_total), 32'd0);
        check("midrst_ready", 32'(act_ready), 32'd1);
        check("midrst_pulses", 32'({act_cmd, rfm_cmd}), 32'd0);
        tick();
        check("postrst_pulses", 32'({act_cmd, rfm_cmd}), 32'd0);
        check("postrst_ready", 32'(act_ready), 32'd1);

        // Randomized run with handshake scoreboard and spacing checks
        last_cyc = -100; last_gap = 0; exp_rfm = 0; exp_raa = 0;
        for (cyc = 0; cyc < 10000; cyc++) begin
            act_valid    = ($urandom_range(0, 1) == 1);
            act_req_addr = ADDR_SIZE'($urandom);
            rfm_req      = ($urandom_range(0, 3) == 0);
            acc          = act_valid && act_ready;
            acc_addr     = act_req_addr;
            tick();
            if (acc !== act_cmd || (acc && act_addr !== acc_addr) || (!acc && act_addr !== '0))
                check("rnd_act", {act_cmd, 13'd0, act_addr}, {acc, 13'd0, (acc ? acc_addr : 18'd0)});
            if (act_cmd && rfm_cmd) check("rnd_both_pulses", 32'd1, 32'd0);
            if (act_cmd || rfm_cmd) begin
                total++;
                if (cyc - last_cyc < last_gap) begin
                    bad++;
                    $error("FAIL rnd_spacing: observed=%0d expected>=%0d", cyc - last_cyc, last_gap);
                end
                last_cyc = cyc;
                last_gap = act_cmd ? ACT_GAP : RFM_GAP;
            end
            if (act_cmd) exp_raa++;
            if (rfm_cmd) begin
                exp_rfm++;
                exp_raa = (exp_raa >= RAA_IMT) ? exp_raa - RAA_IMT : 0;
            end
            if (raa_cnt > RAA_W'(RAA_IMT)) check("rnd_raa_bound", 32'(raa_cnt), 32'(RAA_IMT));
            if (32'(raa_cnt) !== 32'(exp_raa)) check("rnd_raa", 32'(raa_cnt), 32'(exp_raa));
            if (32'(rfm_total) !== 32'(exp_rfm)) check("rnd_total", 32'(rfm_total), 32'(exp_rfm));
        end
        act_valid = 1'b0; rfm_req = 1'b0;
        check("rnd_final_total", 32'(rfm_total), 32'(exp_rfm));
        check("rnd_final_raa", 32'(raa_cnt), 32'(exp_raa));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
